// File: rtl/mem_arbiter_2p.sv
// Two-port arbiter/sequencer for a shared 1-cycle synchronous memory, with lock for atomic RMW.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin contention; default build is fixed priority (port 0).
module mem_arbiter_2p #(
   parameter int AW = 8,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req0,
   input  logic          req1,
   input  logic          we0,
   input  logic          we1,
   input  logic          lock0,
   input  logic          lock1,
   input  logic [AW-1:0] addr0,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] d_i0,
   input  logic [DW-1:0] d_i1,
   output logic          gnt0,
   output logic          gnt1,
   output logic          rvalid0,
   output logic          rvalid1,
   output logic [DW-1:0] d_o,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_d_i,
   input  logic [DW-1:0] mem_d_o
);

   typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

   state_t state;
   logic   pick1;
   logic   g0, g1;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   // Set when port 0 was granted last, so port 1 wins the next IDLE contention.
   logic prio1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    prio1 <= 1'b0;
      else if (gnt0) prio1 <= 1'b1;
      else if (gnt1) prio1 <= 1'b0;
   end

   assign pick1 = prio1;
`else
   assign pick1 = 1'b0;
`endif

   always_comb begin
      g0 = 1'b0;
      g1 = 1'b0;
      case (state)
         IDLE: begin
            if (req0 && req1) begin
               g0 = ~pick1;
               g1 = pick1;
            end else begin
               g0 = req0;
               g1 = req1;
            end
         end
         OWN0:    g0 = req0;
         OWN1:    g1 = req1;
         default: ;
      endcase
   end

   // Grants are combinational, so they must be gated by reset directly.
   assign gnt0 = g0 & rst_n;
   assign gnt1 = g1 & rst_n;

   assign mem_we   = (gnt0 & we0) | (gnt1 & we1);
   assign mem_addr = gnt1 ? addr1 : addr0;
   assign mem_d_i  = gnt1 ? d_i1  : d_i0;
   assign d_o      = mem_d_o;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         rvalid0 <= 1'b0;
         rvalid1 <= 1'b0;
      end else begin
         rvalid0 <= gnt0 & ~we0;
         rvalid1 <= gnt1 & ~we1;
         case (state)
            IDLE: begin
               if (gnt0 && lock0)      state <= OWN0;
               else if (gnt1 && lock1) state <= OWN1;
            end
            OWN0:    if (!req0 || !lock0) state <= IDLE;
            OWN1:    if (!req1 || !lock1) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter_2p.sv
// Directed bench for mem_arbiter_2p with a write-first synchronous memory model attached.
module tb_mem_arbiter_2p;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       req0, req1, we0, we1, lock0, lock1;
   logic [7:0] addr0, addr1, d_i0, d_i1;
   logic       gnt0, gnt1, rvalid0, rvalid1, mem_we;
   logic [7:0] d_o, mem_addr, mem_d_i, mem_d_o;
   logic [7:0] mem [256];
   int         tests = 0;
   int         fails = 0;

   always #5 clk = ~clk;

   mem_arbiter_2p #(.AW(8), .DW(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .lock0(lock0), .lock1(lock1),
      .addr0(addr0), .addr1(addr1), .d_i0(d_i0), .d_i1(d_i1),
      .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
      .d_o(d_o), .mem_we(mem_we), .mem_addr(mem_addr), .mem_d_i(mem_d_i),
      .mem_d_o(mem_d_o)
   );

   always @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_d_i;
      mem_d_o <= mem_we ? mem_d_i : mem[mem_addr];
   end

   task automatic cyc();
      @(posedge clk); #1;
   endtask

   task automatic quiet();
      req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
      addr0 = 0; addr1 = 0; d_i0 = 0; d_i1 = 0;
   endtask

   task automatic test_reset();
      quiet();
      rst_n = 0; req0 = 1; req1 = 1; we0 = 1; lock0 = 1;
      @(negedge clk);
      tests++; if (gnt0 !== 1'b0) begin fails++; $display("FAIL reset_gnt0 got %b want 0", gnt0); end
      tests++; if (gnt1 !== 1'b0) begin fails++; $display("FAIL reset_gnt1 got %b want 0", gnt1); end
      tests++; if (mem_we !== 1'b0) begin fails++; $display("FAIL reset_mem_we got %b want 0", mem_we); end
      tests++; if ({rvalid0, rvalid1} !== 2'b00) begin fails++; $display("FAIL reset_rvalid got %b want 00", {rvalid0, rvalid1}); end
      cyc();
      quiet();
      rst_n = 1;
      cyc();
   endtask

   task automatic test_single_wr_rd();
      req0 = 1; we0 = 1; addr0 = 8'h10; d_i0 = 8'hA5;
      @(negedge clk);
      tests++; if ({gnt0, gnt1, mem_we} !== 3'b101) begin fails++; $display("FAIL wr0_gnt got g0g1we=%b want 101", {gnt0, gnt1, mem_we}); end
      tests++; if (mem_addr !== 8'h10) begin fails++; $display("FAIL wr0_addr got %h want 10", mem_addr); end
      cyc();
      we0 = 0;
      @(negedge clk);
      tests++; if ({gnt0, mem_we, rvalid0} !== 3'b100) begin fails++; $display("FAIL rd0_gnt got g0/we/rv0=%b want 100", {gnt0, mem_we, rvalid0}); end
      cyc();
      quiet();
      @(negedge clk);
      tests++; if ({rvalid0, rvalid1, gnt0} !== 3'b100) begin fails++; $display("FAIL rd0_rvalid got rv0/rv1/g0=%b want 100", {rvalid0, rvalid1, gnt0}); end
      tests++; if (d_o !== 8'hA5) begin fails++; $display("FAIL rd0_data got %h want a5", d_o); end
      cyc();
   endtask

   task automatic test_contention();
      logic [1:0] eg, pg;
      req1 = 1; we1 = 1; addr1 = 8'h20; d_i1 = 8'h3C;
      @(negedge clk);
      tests++; if ({gnt0, gnt1} !== 2'b01) begin fails++; $display("FAIL cont_setup got %b want 01", {gnt0, gnt1}); end
      pg = 2'b00;
      for (int i = 0; i < 4; i++) begin
         cyc();
         req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 8'h20; addr1 = 8'h20;
`ifdef MEM_ARB_ROUND_ROBIN_EN
         eg = (i % 2 == 0) ? 2'b10 : 2'b01;
`else
         eg = 2'b10;
`endif
         @(negedge clk);
         tests++; if ({gnt0, gnt1} !== eg) begin fails++; $display("FAIL cont_gnt[%0d] got %b want %b", i, {gnt0, gnt1}, eg); end
         if (i > 0) begin
            tests++; if ({rvalid0, rvalid1} !== pg) begin fails++; $display("FAIL cont_rvalid[%0d] got %b want %b", i, {rvalid0, rvalid1}, pg); end
            tests++; if (d_o !== 8'h3C) begin fails++; $display("FAIL cont_data[%0d] got %h want 3c", i, d_o); end
         end
         pg = eg;
      end
      cyc();
      quiet();
      @(negedge clk);
      tests++; if ({rvalid0, rvalid1, gnt0, gnt1} !== {pg, 2'b00}) begin fails++; $display("FAIL cont_tail got %b want %b", {rvalid0, rvalid1, gnt0, gnt1}, {pg, 2'b00}); end
      cyc();
   endtask

   task automatic test_lock_rmw();
      req1 = 1; we1 = 1; addr1 = 8'h05; d_i1 = 8'h11;
      cyc();
      we1 = 0; lock1 = 1;
      @(negedge clk);
      tests++; if ({gnt0, gnt1} !== 2'b01) begin fails++; $display("FAIL lock_rd1 got %b want 01", {gnt0, gnt1}); end
      cyc();
      req0 = 1; we0 = 0; addr0 = 8'h05;
      @(negedge clk);
      tests++; if ({gnt0, gnt1} !== 2'b01) begin fails++; $display("FAIL lock_hold got %b want 01", {gnt0, gnt1}); end
      tests++; if ({rvalid1, d_o} !== {1'b1, 8'h11}) begin fails++; $display("FAIL lock_rdata1 got %b/%h want 1/11", rvalid1, d_o); end
      cyc();
      we1 = 1; d_i1 = 8'h77; lock1 = 0;
      @(negedge clk);
      tests++; if ({gnt0, gnt1, mem_we} !== 3'b011) begin fails++; $display("FAIL lock_wr1 got g0g1we=%b want 011", {gnt0, gnt1, mem_we}); end
      cyc();
      req1 = 0; we1 = 0;
      @(negedge clk);
      tests++; if ({gnt0, gnt1, rvalid1} !== 3'b100) begin fails++; $display("FAIL lock_release got g0g1rv1=%b want 100", {gnt0, gnt1, rvalid1}); end
      cyc();
      quiet();
      @(negedge clk);
      tests++; if ({rvalid0, d_o} !== {1'b1, 8'h77}) begin fails++; $display("FAIL lock_rdata0 got %b/%h want 1/77", rvalid0, d_o); end
      cyc();
   endtask

   task automatic test_back_to_back();
      req1 = 1; we1 = 1; addr1 = 8'hFF; d_i1 = 8'h81;
      cyc();
      we1 = 0;
      @(negedge clk);
      tests++; if ({gnt1, mem_we, rvalid1} !== 3'b100) begin fails++; $display("FAIL b2b_rd got g1/we/rv1=%b want 100", {gnt1, mem_we, rvalid1}); end
      cyc();
      quiet();
      @(negedge clk);
      tests++; if ({rvalid1, rvalid0, d_o} !== {2'b10, 8'h81}) begin fails++; $display("FAIL b2b_data got %b/%b/%h want 1/0/81", rvalid1, rvalid0, d_o); end
      cyc();
   endtask

   task automatic test_reset_mid_read();
      req0 = 1; we0 = 0; lock0 = 1; addr0 = 8'h10;
      cyc();
      @(negedge clk);
      tests++; if (gnt0 !== 1'b1) begin fails++; $display("FAIL rst_pre_gnt got %b want 1", gnt0); end
      cyc();
      rst_n = 0;
      @(negedge clk);
      tests++; if ({rvalid0, gnt0, gnt1, mem_we} !== 4'b0000) begin fails++; $display("FAIL rst_mid got rv0/g0/g1/we=%b want 0000", {rvalid0, gnt0, gnt1, mem_we}); end
      cyc();
      rst_n = 1; req0 = 0; lock0 = 0; req1 = 1; we1 = 0; addr1 = 8'h10;
      @(negedge clk);
      tests++; if ({gnt1, rvalid0} !== 2'b10) begin fails++; $display("FAIL rst_unlock got g1/rv0=%b want 10", {gnt1, rvalid0}); end
      cyc();
      quiet();
      @(negedge clk);
      tests++; if ({rvalid0, rvalid1, d_o} !== {2'b01, 8'hA5}) begin fails++; $display("FAIL rst_after got %b/%b/%h want 0/1/a5", rvalid0, rvalid1, d_o); end
      cyc();
   endtask

   task automatic test_idle();
      quiet();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         tests++; if ({mem_we, gnt0, gnt1, rvalid0, rvalid1} !== 5'b0) begin fails++; $display("FAIL idle[%0d] got %b want 00000", i, {mem_we, gnt0, gnt1, rvalid0, rvalid1}); end
         cyc();
      end
   endtask

   initial begin
      test_reset();
      test_single_wr_rd();
      test_contention();
      test_lock_rmw();
      test_back_to_back();
      test_reset_mid_read();
      test_idle();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/mem_arbiter_2p.md
Name: mem_arbiter_2p

Overview:
- Two-requester arbiter and sequencer for the shared 256x8 synchronous data memory.
- Sits between the CPU core (port 0, load/store) and a secondary master (port 1, loader/debug), which share one memory port.
- Grants at most one access per cycle and returns read data with a per-port valid one cycle later.
- Supports a lock so a master can hold the memory for atomic read-modify-write sequences.

Parameters:
- AW, 8, address width; memory depth is 2**AW.
- DW, 8, data width.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req0 / req1  input  1  access request, port 0 / port 1.
- we0 / we1  input  1  write (1) or read (0) qualifier for the request.
- lock0 / lock1  input  1  hold ownership after this access.
- addr0 / addr1  input  AW  request address.
- d_i0 / d_i1  input  DW  write data.
- gnt0 / gnt1  output  1  access accepted this cycle (combinational).
- rvalid0 / rvalid1  output  1  read data valid on d_o (registered).
- d_o  output  DW  read data, shared by both ports; equals mem_d_o.
- mem_we  output  1  to memory write enable.
- mem_addr  output  AW  to memory address.
- mem_d_i  output  DW  to memory write data.
- mem_d_o  input  DW  from memory read data (1-cycle synchronous, write-first).

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; rvalid0=rvalid1=0; priority pointer=port 0 favoured.
  - gnt0, gnt1 and mem_we are forced 0 while rst_n=0.
- State machine: IDLE, OWN0, OWN1.
  - IDLE: winner per arbitration rule.
    - Winner with its lock=1 moves to OWNx on the clock edge.
    - Otherwise stay in IDLE.
  - OWNx: only port x may be granted; the other port's req is ignored (gnt stays 0).
    - Return to IDLE on the edge where the granted port x has lock=0.
    - Also return to IDLE if port x's req=0.
- Grant:
  - gntx = 1 in the same cycle reqx is accepted.
  - Requester holds req/we/addr/d_i until it sees gnt.
  - At most one gnt is high per cycle; no gnt without req.
- Arbitration (default, fixed priority): port 0 wins when both request in IDLE.
- Memory drive:
  - mem_addr/mem_d_i are muxed from the granted port.
  - mem_we = gntx & wex.
  - With no grant: mem_we=0, and mem_addr/mem_d_i hold port 0's values (don't-care).
- Read latency:
  - Read granted at edge N gives rvalidx=1 for exactly the cycle after N.
  - d_o carries the memory output in that cycle.
  - Writes never raise rvalid.
- Throughput:
  - One access per cycle, fully pipelined.
  - Back-to-back grants to alternating ports are legal; each rvalid tracks its own port.
- Read after write: a write at cycle N followed by a read of the same address at N+1 returns the new data (memory is write-first).
- Same-cycle write+read: impossible; only one grant per cycle.
- Reset mid-operation:
  - Pending rvalid is dropped and never appears after release.
  - Lock ownership is cleared.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined:
  - In IDLE with both req=1, the port not granted most recently wins.
  - Pointer updates on every grant, including grants while locked.
  - Reset pointer favours port 0.
- Undefined: fixed priority, port 0 always wins; no pointer register exists.

Test Plan:
- Single write then read, port 0: write 0xA5 to addr 0x10, then read 0x10 -> gnt0 each cycle; rvalid0=1 one cycle after the read grant with d_o=0xA5; rvalid1 stays 0.
- Simultaneous contention:
  - req0=req1=1, both reading addr 0x20=0x3C, held 4 cycles.
  - Fixed build: gnt0 every cycle, gnt1=0.
  - Round-robin build: grants alternate 0,1,0,1, with matching rvalids one cycle later.
- Lock, atomic read-modify-write:
  - Port 1 reads 0x05 with lock1=1 while req0=1 continuously, then writes 0x05=0x77 with lock1=0.
  - Port 0 gets no gnt during both port-1 accesses.
  - gnt0 resumes the cycle after the unlocked write.
  - Port 0's read of 0x05 returns 0x77.
- Back-to-back write/read, port 1: write 0xFF=0x81 at cycle N, read 0xFF at N+1 -> rvalid1 at N+2, d_o=0x81.
- Reset mid-read:
  - Assert rst_n=0 between a port-0 read grant and its rvalid.
  - Required: rvalid0=0, mem_we=0, gnt=0 during reset; no stray rvalid after release.
  - State returns to IDLE, and an earlier lock is cleared.
- Idle: req0=req1=0 for 10 cycles -> mem_we=0, gnt0=gnt1=0, rvalid0=rvalid1=0 throughout.
